// File: rtl/unsigned_div_16by8_seq_if.sv
// Handshake bundle for the sequential 2W/W unsigned divider.
// master: operand producer and result consumer; slave: the divider.
interface unsigned_div_16by8_seq_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     z;
    logic [WIDTH-1:0]       y;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       r;
    logic                   div_zero;
    logic                   overflow;

    modport master (
        output in_valid, z, y, out_ready,
        input  in_ready, out_valid, q, r, div_zero, overflow
    );

    modport slave (
        input  in_valid, z, y, out_ready,
        output in_ready, out_valid, q, r, div_zero, overflow
    );
endinterface

// File: rtl/unsigned_div_16by8_seq.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready on operands and results.
//
// state | meaning
// IDLE  | ready for operands; zero divisor / overflow resolved at accept
// BUSY  | WIDTH restoring iterations, MSB of the low dividend half first
// DONE  | result presented, held until the consumer takes it
module unsigned_div_16by8_seq #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    unsigned_div_16by8_seq_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     rem_q;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0]   shf_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   r_q;
    logic               dz_q;
    logic               ov_q;

    logic [WIDTH-1:0]   z_hi;
    logic [WIDTH-1:0]   z_lo;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH:0]     rem_nx;
    logic [WIDTH-1:0]   shf_nx;

    assign z_hi = bus.z[2*WIDTH-1:WIDTH];
    assign z_lo = bus.z[WIDTH-1:0];

    // One restoring step; the extra remainder bit keeps the shifted-out MSB.
    always_comb begin
        rem_sh = {rem_q[WIDTH-1:0], shf_q[WIDTH-1]};
        rem_ge = (rem_sh >= {1'b0, y_q});
        rem_nx = rem_ge ? (rem_sh - {1'b0, y_q}) : rem_sh;
        shf_nx = {shf_q[WIDTH-2:0], rem_ge};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if ((bus.y == '0) || (z_hi >= bus.y)) state_d = DONE;
                    else                                  state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            shf_q <= '0;
            y_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        y_q <= bus.y;
                        if (bus.y == '0) begin
                            dz_q <= 1'b1;
                            q_q  <= '1;
                            r_q  <= z_lo;
                        end else if (z_hi >= bus.y) begin
                            ov_q <= 1'b1;
                            q_q  <= '1;
                            r_q  <= z_lo;
                        end else begin
                            rem_q <= {1'b0, z_hi};
                            shf_q <= z_lo;
                            cnt_q <= CW'(WIDTH - 1);
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_nx;
                    shf_q <= shf_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        q_q <= shf_nx;
                        r_q <= rem_nx[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        dz_q <= 1'b0;
                        ov_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.q         = q_q;
    assign bus.r         = r_q;
    assign bus.div_zero  = dz_q;
    assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Self-checking bench for unsigned_div_16by8_seq: directed cases plus a
// randomized sweep against a plain-arithmetic reference.
module tb_unsigned_div_16by8_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    unsigned_div_16by8_seq_if #(.WIDTH(W)) bus ();

    unsigned_div_16by8_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: special cases by rule, normal case by integer division.
    task automatic model(input logic [15:0] zv, input logic [7:0] yv,
                         output logic [7:0] eq, output logic [7:0] er,
                         output logic edz, output logic eov, output int elat);
        edz = 1'b0;
        eov = 1'b0;
        if (yv == 8'd0) begin
            edz = 1'b1; eq = 8'hFF; er = zv[7:0]; elat = 1;
        end else if (zv[15:8] >= yv) begin
            eov = 1'b1; eq = 8'hFF; er = zv[7:0]; elat = 1;
        end else begin
            eq = 8'(int'(zv) / int'(yv));
            er = 8'(int'(zv) % int'(yv));
            elat = W + 1;
        end
    endtask

    task automatic run_op(input logic [15:0] zv, input logic [7:0] yv, input int hold);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         elat, lat;
        model(zv, yv, eq, er, edz, eov, elat);
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.z         = zv;
        bus.y         = yv;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.z        = 16'($urandom);
        bus.y        = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("q", 32'(bus.q), 32'(eq));
        check("r", 32'(bus.r), 32'(er));
        check("div_zero", 32'(bus.div_zero), 32'(edz));
        check("overflow", 32'(bus.overflow), 32'(eov));
        if (!edz && !eov) begin
            check("q*y+r==z", int'(bus.q) * int'(yv) + int'(bus.r), 32'(zv));
            check("r<y", 32'(bus.r < yv), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 1);
            bus.z        = 16'h0300;
            bus.y        = 8'h01;
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_q", 32'(bus.q), 32'(eq));
            check("hold_r", 32'(bus.r), 32'(er));
        end
        if (hold > 0) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_flags", 32'({bus.div_zero, bus.overflow}), 32'd0);
        check("post_q_kept", 32'(bus.q), 32'(eq));
        if (hold > 0) begin
            @(posedge clk);
            #1;
            check("no_ghost_op", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] yr, zh, zl;
        n_chk         = 0;
        n_fail        = 0;
        bus.in_valid  = 1'b0;
        bus.z         = '0;
        bus.y         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_qr", 32'({bus.q, bus.r}), 32'd0);
        check("rst_flags", 32'({bus.div_zero, bus.overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 8'h56, 0);
        run_op(16'hFE01, 8'hFF, 0);
        run_op(16'h0100, 8'h00, 0);
        run_op(16'h0507, 8'h05, 0);
        run_op(16'h0064, 8'h07, 5);
        run_op(16'h0000, 8'h01, 0);
        run_op(16'h00FF, 8'h01, 0);

        // Abort in the middle of an iteration.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.z        = 16'h4321;
        bus.y        = 8'h77;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_qr", 32'({bus.q, bus.r}), 32'd0);
        check("midrst_flags", 32'({bus.div_zero, bus.overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("midrst_discarded", 32'(bus.out_valid), 32'd0);
        end
        run_op(16'h00FF, 8'h10, 0);

        for (int i = 0; i < 3000; i++) begin
            yr = 8'($urandom_range(1, 255));
            zh = 8'($urandom_range(0, int'(yr) - 1));
            zl = 8'($urandom);
            run_op({zh, zl}, yr, (i % 97 == 0) ? 2 : 0);
        end
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), (i % 4 == 0) ? 8'd0 : 8'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
